// File: rtl/uart_rx_ctrl_if.sv
// Bus between the UART receive frame controller and its neighbours.
// Carries the serial line and frame configuration, the sampler handshake
// (edge_cnt / dat_samp_en / sampled_bit) and the received-byte outputs.
//   master : the frame controller (drives sampler controls and results)
//   slave  : line/config source, sampler and byte consumer
interface uart_rx_ctrl_if;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic [5:0] edge_cnt;
  logic       dat_samp_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  modport master (
    input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    output edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller.
// Sequences start/data/parity/stop bits, drives the oversample index for the
// sampler, deserialises the byte LSB-first, checks parity and stop, and
// publishes the byte with a one-cycle data_valid strobe.
// Ports:
//   clk_RX : oversampling clock
//   rst    : asynchronous active-low reset
//   bus    : uart_rx_ctrl_if.master (line, config, sampler handshake, results)
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic           clk_RX,
  input  logic           rst,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_nxt;
  logic [5:0]          eff_ps, ps_dec, edge_cnt;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   shreg, p_data;
  logic                par_en_q, par_typ_q, par_mis;
  logic                dv, par_err, stp_err;
  logic                bit_end, start_det;

  // Unsupported ratios fall back to 8.
  always_comb begin
    ps_dec = 6'd8;
    case (bus.prescale)
      6'd16:   ps_dec = 6'd16;
      6'd32:   ps_dec = 6'd32;
      default: ps_dec = 6'd8;
    endcase
  end

  assign bit_end = (state != IDLE) && (edge_cnt == eff_ps - 6'd1);

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    case (state)
      IDLE:
        if (!bus.RX_IN) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      START:
        if (bit_end) state_nxt = bus.sampled_bit ? IDLE : DATA;
      DATA:
        if (bit_end && bit_cnt == 3'(DATA_W-1))
          state_nxt = par_en_q ? PARITY : STOP;
      PARITY:
        if (bit_end) state_nxt = STOP;
      STOP:
        if (bit_end) begin
          // Line already low at the stop sample point: next start bit began.
          if (!bus.RX_IN) begin
            state_nxt = START;
            start_det = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      eff_ps    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      p_data    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_mis   <= 1'b0;
      dv        <= 1'b0;
      par_err   <= 1'b0;
      stp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      dv    <= 1'b0;
      edge_cnt <= (state == IDLE || bit_end) ? 6'd0 : edge_cnt + 6'd1;

      // Frame config is frozen at start detection.
      if (start_det) begin
        eff_ps    <= ps_dec;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        par_mis   <= 1'b0;
        bit_cnt   <= '0;
      end

      // Flags clear on a fresh start from IDLE; on a back-to-back start the
      // STOP branch below writes this frame's result on the same edge.
      if (start_det && state == IDLE) begin
        par_err <= 1'b0;
        stp_err <= 1'b0;
      end

      if (bit_end) begin
        case (state)
          DATA: begin
            shreg[bit_cnt] <= bus.sampled_bit;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          PARITY:
            par_mis <= bus.sampled_bit ^ (^shreg) ^ par_typ_q;
          STOP: begin
            stp_err <= ~bus.sampled_bit;
            par_err <= par_mis;
            if (bus.sampled_bit && !par_mis) begin
              p_data <= shreg;
              dv     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.dat_samp_en = (state != IDLE);
  assign bus.P_DATA      = p_data;
  assign bus.data_valid  = dv;
  assign bus.par_err     = par_err;
  assign bus.stp_err     = stp_err;

endmodule
